// File: rtl/csi2_pattern_gen.sv
// Synthetic CSI-2 frame source: FS, per-line long-packet headers with RAW8
// colour-bar or ramp payload, FE, all paced by the packetiser's tx_ready.
module csi2_pattern_gen #(
    parameter int          H_ACTIVE      = 640,
    parameter int          V_ACTIVE      = 480,
    parameter int          H_BLANK       = 64,
    parameter int          V_BLANK       = 8,
    parameter int          FS_GAP        = 16,
    parameter int          BAR_WIDTH     = 80,
    parameter logic [5:0]  DATA_TYPE     = 6'h2A,
    parameter logic [15:0] FRAME_NUM_MAX = 16'd65535
) (
    input  logic        CLKOS,
    input  logic        RST,
    input  logic        enable,
    input  logic        pattern_sel,
    input  logic        tx_ready,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        data_valid,
    output logic [7:0]  data,
    output logic [5:0]  data_type,
    output logic [15:0] word_count,
    output logic        busy
);

    localparam logic [15:0] X_LAST   = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
    localparam logic [15:0] GAP_LAST = 16'(FS_GAP - 1);
    localparam logic [15:0] BAR_LAST = 16'(BAR_WIDTH - 1);
    localparam logic [15:0] H_WC     = 16'(H_ACTIVE);
    localparam logic [31:0] VB_LEN   = 32'(longint'(V_BLANK) * longint'(H_ACTIVE + H_BLANK));
    localparam logic [31:0] VB_LAST  = VB_LEN - 32'd1;

    typedef enum logic [2:0] {IDLE, FS, FS_WAIT, LS, ACTIVE, HBLANK, FE, VBLANK} state_t;

    state_t      state, state_nxt;
    logic [15:0] x, x_nxt, y, y_nxt;
    logic [15:0] blank_cnt, blank_nxt;
    logic [31:0] vblank_cnt, vblank_nxt;
    logic [15:0] frame_num, frame_num_nxt;
    logic [15:0] bar_pos, bar_pos_nxt;
    logic [2:0]  bar, bar_nxt;
    logic        pat, pat_nxt;
    logic        enable_q;
    logic        line_done, frame_done;
    logic [7:0]  data_nxt;

    // Next-state logic; every counter only moves on a transfer or an idle tick,
    // so a stall leaves the whole frame position frozen.
    always_comb begin
        state_nxt     = state;
        x_nxt         = x;
        y_nxt         = y;
        blank_nxt     = blank_cnt;
        vblank_nxt    = vblank_cnt;
        frame_num_nxt = frame_num;
        bar_pos_nxt   = bar_pos;
        bar_nxt       = bar;
        pat_nxt       = pat;
        line_done     = 1'b0;
        frame_done    = 1'b0;

        case (state)
            IDLE: begin
                if (enable_q) state_nxt = FS;
            end
            FS: begin
                if (tx_ready) begin
                    pat_nxt   = pattern_sel;
                    y_nxt     = '0;
                    blank_nxt = '0;
                    state_nxt = (FS_GAP == 0) ? LS : FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (blank_cnt == GAP_LAST) state_nxt = LS;
                else                       blank_nxt = blank_cnt + 16'd1;
            end
            LS: begin
                if (tx_ready) begin
                    x_nxt       = '0;
                    bar_nxt     = '0;
                    bar_pos_nxt = '0;
                    state_nxt   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (tx_ready) begin
                    if (x == X_LAST) begin
                        blank_nxt = '0;
                        if (H_BLANK == 0) line_done = 1'b1;
                        else              state_nxt = HBLANK;
                    end else begin
                        x_nxt = x + 16'd1;
                        // Bar index saturates at 7 so wide lines end on the last bar
                        if (bar_pos == BAR_LAST) begin
                            bar_pos_nxt = '0;
                            if (bar != 3'd7) bar_nxt = bar + 3'd1;
                        end else begin
                            bar_pos_nxt = bar_pos + 16'd1;
                        end
                    end
                end
            end
            HBLANK: begin
                if (blank_cnt == HB_LAST) line_done = 1'b1;
                else                      blank_nxt = blank_cnt + 16'd1;
            end
            FE: begin
                if (tx_ready) begin
                    frame_num_nxt = (frame_num == FRAME_NUM_MAX) ? 16'd1 : frame_num + 16'd1;
                    vblank_nxt    = '0;
                    if (VB_LEN == 32'd0) frame_done = 1'b1;
                    else                 state_nxt  = VBLANK;
                end
            end
            VBLANK: begin
                if (vblank_cnt == VB_LAST) frame_done = 1'b1;
                else                       vblank_nxt = vblank_cnt + 32'd1;
            end
            default: state_nxt = IDLE;
        endcase

        if (line_done) begin
            if (y < Y_LAST) begin
                y_nxt     = y + 16'd1;
                state_nxt = LS;
            end else begin
                state_nxt = FE;
            end
        end
        if (frame_done) state_nxt = enable_q ? FS : IDLE;

        data_nxt = pat_nxt ? (x_nxt[7:0] + y_nxt[7:0]) : {~bar_nxt, 5'h1F};
    end

    // Outputs are decoded from the next state and registered, so they always
    // line up with the state register and never depend combinationally on tx_ready.
    always_ff @(posedge CLKOS or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            blank_cnt   <= '0;
            vblank_cnt  <= '0;
            frame_num   <= 16'd1;
            bar_pos     <= '0;
            bar         <= '0;
            pat         <= 1'b0;
            enable_q    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            data_valid  <= 1'b0;
            data        <= '0;
            data_type   <= '0;
            word_count  <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            blank_cnt   <= blank_nxt;
            vblank_cnt  <= vblank_nxt;
            frame_num   <= frame_num_nxt;
            bar_pos     <= bar_pos_nxt;
            bar         <= bar_nxt;
            pat         <= pat_nxt;
            enable_q    <= enable;
            frame_start <= (state_nxt == FS);
            frame_end   <= (state_nxt == FE);
            line_start  <= (state_nxt == LS);
            data_valid  <= (state_nxt == ACTIVE);
            busy        <= (state_nxt != IDLE);
            data_type   <= (state_nxt == LS) ? DATA_TYPE : 6'd0;
            data        <= (state_nxt == ACTIVE) ? data_nxt : 8'd0;
            case (state_nxt)
                FS, FE:  word_count <= frame_num_nxt;
                LS:      word_count <= H_WC;
                default: word_count <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_pattern_gen.sv
// Bench for csi2_pattern_gen: transfers are compared against a frame model
// built from the packet sequence and pixel formulas, under varied tx_ready pacing.
module tb_csi2_pattern_gen;

    localparam int H   = 8;
    localparam int V   = 2;
    localparam int HB  = 2;
    localparam int FSG = 3;
    localparam int VB  = 1;
    localparam int BW  = 2;

    localparam logic [1:0] K_FS = 2'd0;
    localparam logic [1:0] K_LS = 2'd1;
    localparam logic [1:0] K_PX = 2'd2;
    localparam logic [1:0] K_FE = 2'd3;

    logic        CLKOS = 1'b0;
    logic        RST;
    logic        enable;
    logic        pattern_sel;
    logic        tx_ready;
    logic        frame_start;
    logic        frame_end;
    logic        line_start;
    logic        data_valid;
    logic [7:0]  data;
    logic [5:0]  data_type;
    logic [15:0] word_count;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [31:0] exp_q[$];

    always #5 CLKOS = ~CLKOS;

    csi2_pattern_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB), .FS_GAP(FSG),
        .BAR_WIDTH(BW), .DATA_TYPE(6'h2A), .FRAME_NUM_MAX(16'd3)
    ) dut (
        .CLKOS(CLKOS), .RST(RST), .enable(enable), .pattern_sel(pattern_sel),
        .tx_ready(tx_ready), .frame_start(frame_start), .frame_end(frame_end),
        .line_start(line_start), .data_valid(data_valid), .data(data),
        .data_type(data_type), .word_count(word_count), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge CLKOS);
        cyc++;
    endtask

    function automatic logic [7:0] model_px(input logic sel, input int x, input int y);
        int bar;
        if (sel) return 8'((x + y) % 256);
        bar = x / BW;
        if (bar > 7) bar = 7;
        return 8'(255 - 32 * bar);
    endfunction

    task automatic build_frame(input logic sel, input logic [15:0] fn);
        exp_q.push_back({K_FS, fn, 6'h00, 8'h00});
        for (int y = 0; y < V; y++) begin
            exp_q.push_back({K_LS, 16'(H), 6'h2A, 8'h00});
            for (int x = 0; x < H; x++)
                exp_q.push_back({K_PX, 16'h0000, 6'h00, model_px(sel, x, y)});
        end
        exp_q.push_back({K_FE, fn, 6'h00, 8'h00});
    endtask

    // mode 0: tx_ready always 1, 1: alternating, 2: random with ~25% stalls
    task automatic run_frame(input logic sel, input logic [15:0] fn, input int mode,
                             input bit flip_sel, input bit drop_en);
        logic [33:0] vec, prev_vec;
        logic [31:0] ev;
        logic        req;
        bit          held, flip_pend;
        int          fs_cyc, ls_cyc, n_ls, budget;
        pattern_sel = sel;
        build_frame(sel, fn);
        held = 0; flip_pend = 0; n_ls = 0; budget = 0; fs_cyc = 0; ls_cyc = 0;
        prev_vec = '0;
        while (exp_q.size() > 0 && budget < 2000) begin
            tick();
            budget++;
            if (flip_pend) begin
                pattern_sel = ~sel;
                flip_pend   = 0;
            end
            vec = {frame_start, frame_end, line_start, data_valid, data, word_count, data_type};
            req = frame_start | frame_end | line_start | data_valid;
            check("one_request", 64'($countones({frame_start, frame_end, line_start, data_valid}) <= 1), 64'd1);
            if (held) check("stall_hold", 64'(vec), 64'(prev_vec));
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = cyc[0];
                default: tx_ready = ($urandom_range(3) != 0);
            endcase
            held     = req && !tx_ready;
            prev_vec = vec;
            if (req && tx_ready) begin
                ev = {frame_start ? K_FS : line_start ? K_LS : data_valid ? K_PX : K_FE,
                      word_count, data_type, data_valid ? data : 8'h00};
                check("transfer", 64'(ev), 64'(exp_q.pop_front()));
                if (frame_start) begin
                    fs_cyc = cyc;
                    if (flip_sel) flip_pend = 1;
                end
                if (line_start) begin
                    if (mode == 0) begin
                        if (n_ls == 0) check("fs_to_ls", 64'(cyc - fs_cyc), 64'(FSG + 1));
                        else           check("ls_to_ls", 64'(cyc - ls_cyc), 64'(1 + H + HB));
                    end
                    ls_cyc = cyc;
                    n_ls++;
                    if (drop_en) enable = 1'b0;
                end
            end
        end
        check("frame_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fs"},   64'(frame_start), 64'd0);
        check({tag, "_fe"},   64'(frame_end),   64'd0);
        check({tag, "_ls"},   64'(line_start),  64'd0);
        check({tag, "_dv"},   64'(data_valid),  64'd0);
        check({tag, "_data"}, 64'(data),        64'd0);
        check({tag, "_dt"},   64'(data_type),   64'd0);
        check({tag, "_wc"},   64'(word_count),  64'd0);
        check({tag, "_busy"}, 64'(busy),        64'd0);
    endtask

    initial begin
        int n;
        RST = 1'b1; enable = 1'b0; pattern_sel = 1'b0; tx_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");

        enable = 1'b1;
        RST    = 1'b0;
        tick();
        check("por_edge1_fs", 64'(frame_start), 64'd0);
        tick();
        check("por_edge2_fs", 64'(frame_start), 64'd1);
        check("por_edge2_wc", 64'(word_count), 64'd1);

        run_frame(1'b0, 16'd1, 0, 0, 0);
        run_frame(1'b1, 16'd2, 1, 1, 0);
        run_frame(1'($urandom_range(1)), 16'd3, 2, 0, 0);
        run_frame(1'($urandom_range(1)), 16'd1, 2, 0, 1);

        for (int i = 0; i < 14; i++) begin
            tick();
            tx_ready = ($urandom_range(1) != 0);
            check("no_restart", 64'(frame_start), 64'd0);
        end
        check("idle_busy", 64'(busy), 64'd0);

        enable   = 1'b1;
        tx_ready = 1'b1;
        n = 0;
        while (!data_valid && n < 200) begin
            tick();
            n++;
        end
        check("reach_active", 64'(data_valid), 64'd1);
        RST = 1'b1;
        #1;
        check_all_zero("mid_rst");
        tx_ready = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        tick();
        check("rel_edge1_fs", 64'(frame_start), 64'd0);
        tick();
        check("rel_edge2_fs", 64'(frame_start), 64'd1);
        check("rel_edge2_wc", 64'(word_count), 64'd1);
        run_frame(1'($urandom_range(1)), 16'd1, 2, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
